oflow_prev_frame_reader: RTL

OFLOW_PREV_FRAME_READER -- requirements
Module: oflow_prev_frame_reader

---
 rtl/oflow_core_define_pkg.sv | 17 +
 rtl/oflow_prev_frame_reader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/oflow_core_define_pkg.sv
// Shared oflow core definitions: datapath widths and the previous-frame
// reader state encoding.
package oflow_core_define_pkg;

   localparam int DATA_TO_PE_WIDTH = 256;
   localparam int ROW_LEN          = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      CAP,
      WAIT,
      DONE
   } oflow_rd_state_e;

endpackage

// File: rtl/oflow_prev_frame_reader.sv
// Streams stored previous-frame entries, two at a time, from a synchronous
// entry memory into the two similarity-metric slots.
module oflow_prev_frame_reader
   import oflow_core_define_pkg::*;
#(
   parameter int DATA_W = DATA_TO_PE_WIDTH,
   parameter int ADDR_W = 7
) (
   input  logic                  clk,
   input  logic                  reset_N,
   input  logic                  start_read,
   input  logic [ADDR_W:0]       num_of_objects,
   input  logic                  control_for_read_new_line,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_rd_data,
   output logic [DATA_W-1:0]     data_to_similarity_metric_0,
   output logic [DATA_W-1:0]     data_to_similarity_metric_1,
   output logic                  valid_0,
   output logic                  valid_1,
   output logic                  pair_valid,
   output logic                  done_read,
   output logic                  busy,
   output oflow_rd_state_e       dbg_state_o
);

   localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

   oflow_rd_state_e       state_q, state_d;
   logic [ADDR_W:0]       ptr_q, ptr_d;
   logic [ADDR_W:0]       count_q, count_d;
   logic                  pending_q, pending_d;
   logic [DATA_W-1:0]     slot0_q, slot0_d;
   logic [DATA_W-1:0]     slot1_q, slot1_d;
   logic                  valid0_q, valid0_d;
   logic                  valid1_q, valid1_d;
   logic                  done_q, done_d;

   // One bit wider than ptr so ptr+1 / ptr+2 never wrap before the compare.
   logic [ADDR_W+1:0]     ptr_plus1, ptr_plus2, count_ext;
   logic                  second_rd;

   assign ptr_plus1 = {1'b0, ptr_q} + (ADDR_W+2)'(1);
   assign ptr_plus2 = {1'b0, ptr_q} + (ADDR_W+2)'(2);
   assign count_ext = {1'b0, count_q};
   assign second_rd = (ptr_plus1 < count_ext);

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         slot0_q   <= '0;
         slot1_q   <= '0;
         valid0_q  <= 1'b0;
         valid1_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         slot0_q   <= slot0_d;
         slot1_q   <= slot1_d;
         valid0_q  <= valid0_d;
         valid1_q  <= valid1_d;
         done_q    <= done_d;
      end
   end

   // Handshake: pair_valid is high only while parked in WAIT; a request
   // (pulse, or one remembered from RD0/RD1/CAP) consumes the pair there.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      pending_d = pending_q;
      slot0_d   = slot0_q;
      slot1_d   = slot1_q;
      valid0_d  = valid0_q;
      valid1_d  = valid1_q;
      done_d    = done_q;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      pair_valid = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start_read) begin
               if (num_of_objects != '0) begin
                  count_d   = (num_of_objects > MAX_COUNT) ? MAX_COUNT : num_of_objects;
                  ptr_d     = '0;
                  done_d    = 1'b0;
                  pending_d = 1'b0;
                  state_d   = RD0;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         RD0: begin
            mem_rd_en = 1'b1;
            mem_addr  = ptr_q[ADDR_W-1:0];
            if (control_for_read_new_line) pending_d = 1'b1;
            state_d = RD1;
         end
         RD1: begin
            if (second_rd) begin
               mem_rd_en = 1'b1;
               mem_addr  = ptr_plus1[ADDR_W-1:0];
            end
            slot0_d  = mem_rd_data;
            valid0_d = 1'b1;
            if (control_for_read_new_line) pending_d = 1'b1;
            state_d = CAP;
         end
         CAP: begin
            // ptr is unchanged since RD1, so second_rd still says whether a
            // second read was issued.
            if (second_rd) begin
               slot1_d  = mem_rd_data;
               valid1_d = 1'b1;
            end else begin
               slot1_d  = '0;
               valid1_d = 1'b0;
            end
            ptr_d = (ptr_plus2 >= count_ext) ? count_q : ptr_plus2[ADDR_W:0];
            if (control_for_read_new_line) pending_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            pair_valid = 1'b1;
            if (control_for_read_new_line || pending_q) begin
               pending_d = 1'b0;
               if (ptr_q < count_q) begin
                  state_d = RD0;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_to_similarity_metric_0 = slot0_q;
   assign data_to_similarity_metric_1 = slot1_q;
   assign valid_0     = valid0_q;
   assign valid_1     = valid1_q;
   assign done_read   = done_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule
